// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt dispatch controller.
// Optional rotating priority is selected with INTERRUPT_ROUND_ROBIN_EN.
package interrupt_pkg;

  localparam int DEFAULT_N = 8;
  localparam int ID_W      = $clog2(DEFAULT_N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/interrupt_priority_encoder.sv
// Combinational arbiter: scans req_i downward from start_i, wrapping 0 -> N-1,
// and reports the first set line.
module interrupt_priority_encoder
  import interrupt_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] index_o
);

  localparam int IdW = $clog2(N);

  logic [IdW-1:0] pos;

  // Walk from the farthest distance to the nearest so the closest hit is kept.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    pos     = '0;
    for (int d = N - 1; d >= 0; d--) begin
      pos = IdW'((int'(start_i) + N - d) % N);
      if (req_i[pos]) begin
        valid_o = 1'b1;
        index_o = pos;
      end
    end
  end

endmodule

// File: rtl/interrupt_dispatch.sv
// Interrupt dispatch controller: IDLE/REQ/SERVICE handshake with the pipeline.
// Define INTERRUPT_ROUND_ROBIN_EN for rotating priority instead of highest-index-wins.
module interrupt_dispatch
  import interrupt_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         pending,
  input  logic [N-1:0]         im,
  input  logic                 ie,
  input  logic                 exl,
  input  logic                 erl,
  input  logic                 int_ack,
  input  logic                 eret,
  output logic                 int_req,
  output logic [$clog2(N)-1:0] int_id,
  output logic [N-1:0]         int_ip,
  output logic                 storage_clear,
  output logic                 busy
);

  localparam int IdW = $clog2(N);

  state_e         state_q, state_d;
  logic [IdW-1:0] int_id_q, int_id_d;
  logic [N-1:0]   int_ip_q;
  logic           storage_clear_q, storage_clear_d;

  logic [N-1:0]   eligible;
  logic [IdW-1:0] start_idx;
  logic           arb_valid;
  logic [IdW-1:0] arb_idx;
  logic           ack_taken;

  assign eligible  = (ie && !exl && !erl) ? (pending & im) : '0;
  assign ack_taken = (state_q == REQ) && int_ack;

`ifdef INTERRUPT_ROUND_ROBIN_EN
  logic [IdW-1:0] last_q, last_d;

  assign last_d    = ack_taken ? int_id_q : last_q;
  // Search begins just below the last granted line, wrapping below zero.
  assign start_idx = (last_q == '0) ? IdW'(N - 1) : (last_q - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign start_idx = IdW'(N - 1);
`endif

  interrupt_priority_encoder #(
    .N(N)
  ) u_prio (
    .req_i   (eligible),
    .start_i (start_idx),
    .valid_o (arb_valid),
    .index_o (arb_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // int_ack wins over eligible collapsing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_valid) state_d = REQ;
      REQ: begin
        if (int_ack)         state_d = SERVICE;
        else if (!arb_valid) state_d = IDLE;
      end
      SERVICE: if (eret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    int_req = 1'b0;
    busy    = 1'b0;
    case (state_q)
      REQ:     int_req = 1'b1;
      SERVICE: busy    = 1'b1;
      default: ;
    endcase
  end

  // Winner is tracked while requesting and frozen once acknowledged.
  always_comb begin
    int_id_d        = int_id_q;
    storage_clear_d = ack_taken;
    case (state_q)
      IDLE:    if (arb_valid) int_id_d = arb_idx;
      REQ:     if (!int_ack && arb_valid) int_id_d = arb_idx;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_id_q        <= '0;
      int_ip_q        <= '0;
      storage_clear_q <= 1'b0;
    end else begin
      int_id_q        <= int_id_d;
      int_ip_q        <= pending;
      storage_clear_q <= storage_clear_d;
    end
  end

  assign int_id        = int_id_q;
  assign int_ip        = int_ip_q;
  assign storage_clear = storage_clear_q;

endmodule

// File: doc/interrupt_dispatch.md
INTERRUPT_DISPATCH -- requirements
Module: interrupt_dispatch

Interface
REQ-001 Parameter N, default 8, number of interrupt lines, which SHALL be at least 2.
REQ-002 The port list SHALL be as follows.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- pending  input  N  latched interrupt lines from the interrupt storage block.
- im  input  N  per-line enable from CP0 Status.IM.
- ie, exl, erl  input  1 each  CP0 Status.IE, EXL and ERL.
- int_ack  input  1  pipeline has taken the interrupt exception; meaningful only while int_req is high.
- eret  input  1  single-cycle pulse when ERET retires.
- int_req  output  1  interrupt exception request to the pipeline.
- int_id  output  $clog2(N)  index of the winning line.
- int_ip  output  N  registered copy of pending, for Cause.IP.
- storage_clear  output  1  single-cycle clear pulse to the interrupt storage block.
- busy  output  1  high while an interrupt is being serviced.

Function
REQ-003 eligible SHALL be pending & im, gated to zero unless ie=1, exl=0 and erl=0.
REQ-004 The controller SHALL be a three-state FSM: IDLE, REQ, SERVICE.
REQ-005 In IDLE, if eligible is non-zero in cycle t, the block SHALL register the winner into int_id and enter REQ, so int_req is high in cycle t+1.
REQ-006 In REQ, int_id SHALL be re-arbitrated every cycle from the current eligible value; if eligible becomes zero with int_ack low, the FSM SHALL return to IDLE and int_req SHALL drop in the next cycle.
REQ-007 In REQ with int_ack=1, the FSM SHALL enter SERVICE, freeze int_id, and pulse storage_clear for exactly the following cycle; int_ack SHALL take priority over eligible falling in the same cycle.
REQ-008 In SERVICE: int_req=0, busy=1, no arbitration; eret=1 SHALL return the FSM to IDLE, with a new request possible no earlier than 2 cycles after eret.
REQ-009 eret in IDLE or REQ, and int_ack outside REQ, SHALL be ignored.
REQ-010 int_ip SHALL equal pending delayed by one cycle in every state.
REQ-011 Default priority SHALL be fixed: the highest set index of eligible wins.
REQ-012 Nested interrupts SHALL NOT be supported; lines raised during SERVICE wait in storage.

Reset
REQ-013 Reset SHALL force the FSM to IDLE, clear int_req, int_id, int_ip, storage_clear and busy, and clear the round-robin pointer.
REQ-014 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the interrupt with no storage_clear pulse.

Configuration
REQ-015 With INTERRUPT_ROUND_ROBIN_EN defined, priority SHALL rotate.
- A last-granted pointer is updated on each int_ack.
- The search starts at (last-1) mod N, descends, and wraps from index 0 to N-1.
REQ-016 Without INTERRUPT_ROUND_ROBIN_EN, fixed priority per REQ-011 SHALL apply and no pointer register SHALL exist.

Structure
REQ-017 A shared package interrupt_pkg SHALL hold:
- the FSM state enum (IDLE, REQ, SERVICE);
- the default line-count constant;
- the id-width localparam.
REQ-018 Arbitration SHALL be a combinational sub-module interrupt_priority_encoder with:
- inputs: request vector, start index;
- outputs: valid, index.
Fixed priority uses start index N-1.

Verification
REQ-019 The bench SHALL cover at least the following scenarios, each with the stated response.
- pending=8'h84, im=8'hFF, ie=1, exl=0 -> int_req high the next cycle, int_id=7; int_ack -> one-cycle storage_clear, busy=1.
- pending=8'h04, im=8'hFB, ie=1 -> int_req stays 0; setting im=8'hFF -> int_req=1, int_id=2 one cycle later.
- In REQ with int_id=3, pending drops to 0 with int_ack=0 -> int_req=0 next cycle, FSM in IDLE, no storage_clear.
- int_ack and pending-falling in the same cycle -> SERVICE entered, storage_clear pulsed; eret -> IDLE, busy=0.
- With INTERRUPT_ROUND_ROBIN_EN and pending=8'h81 held -> successive grants are 7, 0, 7, 0 across ack/eret cycles.
- reset asserted during SERVICE -> all outputs 0 that cycle, FSM in IDLE, later eret ignored.
